// File: rtl/bus_sram_slave.sv
// bus_sram_slave: single-port 32-bit SRAM behind an asynchronous-strobe bus
// slave with a programmable number of wait states and a one-cycle ready pulse.
// Optional feature macro: BUS_SRAM_SLAVE_ERR_EN adds an active-low s_errn
// output that flags accesses whose upper word-address bits are nonzero.
module bus_sram_slave #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [29:0] s_addr,
    input  logic        s_asn,
    input  logic        s_rw,
    input  logic [31:0] s_wdata,
    output logic [31:0] s_rdata,
`ifdef BUS_SRAM_SLAVE_ERR_EN
    output logic        s_rdyn,
    output logic        s_errn
`else
    output logic        s_rdyn
`endif
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;

    // Last counter value spent in WAIT before moving to ACK.
    localparam logic [CNT_W-1:0] WAIT_LAST =
        (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    rw_q;
    logic [DATA_W-1:0]       wdata_q;
    logic                    err_q;
    logic [DATA_W-1:0]       rdata_q;
    logic                    rdyn_q;
    logic                    addr_err;
    logic                    mem_we;

    logic [DATA_W-1:0]       mem_q [DEPTH];

`ifdef BUS_SRAM_SLAVE_ERR_EN
    logic                    errn_q;

    // Out-of-range access: any decoded-away upper address bit set.
    assign addr_err = |s_addr[29:ADDR_WIDTH];
`else
    logic                    unused_addr_hi;

    // Upper address bits are ignored, so addresses alias into the array.
    assign addr_err       = 1'b0;
    assign unused_addr_hi = ^s_addr[29:ADDR_WIDTH];
`endif

    // Transaction FSM: capture, wait states, ack pulse, hold until strobe release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b1;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            rdyn_q  <= 1'b1;
        end else begin
            rdyn_q  <= 1'b1;
            rdata_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (!s_asn) begin
                        addr_q  <= s_addr[ADDR_WIDTH-1:0];
                        rw_q    <= s_rw;
                        wdata_q <= s_wdata;
                        err_q   <= addr_err;
                        cnt_q   <= '0;
                        state_q <= (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (s_asn) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == WAIT_LAST) begin
                        state_q <= ST_ACK;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_ACK: begin
                    rdyn_q  <= 1'b0;
                    if (rw_q && !err_q) begin
                        rdata_q <= mem_q[addr_q];
                    end
                    state_q <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (s_asn) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef BUS_SRAM_SLAVE_ERR_EN
    // Error flag pulses alongside ready for out-of-range accesses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            errn_q <= 1'b1;
        end else begin
            errn_q <= !((state_q == ST_ACK) && err_q);
        end
    end

    assign s_errn = errn_q;
`endif

    // Write commits on the edge leaving ACK; a reset in ACK drops it.
    assign mem_we = (state_q == ST_ACK) && !rw_q && !err_q;

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign s_rdata = rdata_q;
    assign s_rdyn  = rdyn_q;

endmodule

// File: tb/tb_bus_sram_slave.sv
// tb_bus_sram_slave: three instances of bus_sram_slave with WAIT_CYCLES of
// 1, 0 and 3; honours BUS_SRAM_SLAVE_ERR_EN when it is defined.
module tb_bus_sram_slave;

`ifdef BUS_SRAM_SLAVE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        int          d;
        logic        rw;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        errn;
        int          hold;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        errn;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  asn;
    logic [2:0]  rw;
    logic [2:0]  rdyn;
    logic [29:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
`ifdef BUS_SRAM_SLAVE_ERR_EN
    logic [2:0]  errn;
`endif

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb0[$];
    exp_t sb1[$];
    exp_t sb2[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    bus_sram_slave #(.ADDR_WIDTH(8), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .reset_n(reset_n), .s_addr(addr[0]), .s_asn(asn[0]),
        .s_rw(rw[0]), .s_wdata(wdata[0]), .s_rdata(rdata[0]), .s_rdyn(rdyn[0])
`ifdef BUS_SRAM_SLAVE_ERR_EN
        , .s_errn(errn[0])
`endif
    );

    bus_sram_slave #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .reset_n(reset_n), .s_addr(addr[1]), .s_asn(asn[1]),
        .s_rw(rw[1]), .s_wdata(wdata[1]), .s_rdata(rdata[1]), .s_rdyn(rdyn[1])
`ifdef BUS_SRAM_SLAVE_ERR_EN
        , .s_errn(errn[1])
`endif
    );

    bus_sram_slave #(.ADDR_WIDTH(8), .WAIT_CYCLES(3)) u_dut_w3 (
        .clk(clk), .reset_n(reset_n), .s_addr(addr[2]), .s_asn(asn[2]),
        .s_rw(rw[2]), .s_wdata(wdata[2]), .s_rdata(rdata[2]), .s_rdyn(rdyn[2])
`ifdef BUS_SRAM_SLAVE_ERR_EN
        , .s_errn(errn[2])
`endif
    );

    function automatic int wc(input int d);
        case (d)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic void sb_push(input int d, input exp_t e);
        case (d)
            0:       sb0.push_back(e);
            1:       sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
    endfunction

    function automatic int sb_size(input int d);
        case (d)
            0:       return sb0.size();
            1:       return sb1.size();
            default: return sb2.size();
        endcase
    endfunction

    function automatic exp_t sb_pop(input int d);
        case (d)
            0:       return sb0.pop_front();
            1:       return sb1.pop_front();
            default: return sb2.pop_front();
        endcase
    endfunction

    function automatic void add(input int d, input logic r, input logic [29:0] a,
                                input logic [31:0] w, input logic [31:0] er,
                                input logic ee, input int h);
        vec_t v;
        v.d = d; v.rw = r; v.addr = a; v.wdata = w;
        v.rdata = er; v.errn = ee; v.hold = h;
        vecs.push_back(v);
    endfunction

    task automatic drive(input int d, input logic a_n, input logic r,
                         input logic [29:0] a, input logic [31:0] w);
        asn[d]   = a_n;
        rw[d]    = r;
        addr[d]  = a;
        wdata[d] = w;
    endtask

    // One strobe, called and returning at a falling edge; the next strobe
    // issued right after lands 3+WAIT_CYCLES edges later.
    task automatic do_txn(input vec_t v);
        exp_t e;
        int   w;
        w       = wc(v.d);
        e.cyc   = cyc + 2 + w;
        e.rdata = v.rdata;
        e.errn  = v.errn;
        sb_push(v.d, e);
        drive(v.d, 1'b0, v.rw, v.addr, v.wdata);
        @(posedge clk);
        @(negedge clk);
        drive(v.d, 1'b0, 1'($urandom), 30'($urandom), $urandom);
        repeat (1 + w + v.hold) @(negedge clk);
        asn[v.d] = 1'b1;
        @(negedge clk);
    endtask

    // Output monitor: match every ready pulse against the expectation queue.
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset_n) begin
            for (int d = 0; d < 3; d++) begin
                if (rdyn[d] == 1'b0) begin
                    if (sb_size(d) == 0) begin
                        chk($sformatf("dut%0d_unexpected_ack", d), 32'(rdyn[d]), 32'd1);
                    end else begin
                        e = sb_pop(d);
                        chk($sformatf("dut%0d_ack_cycle", d), 32'(cyc), 32'(e.cyc));
                        chk($sformatf("dut%0d_ack_rdata", d), rdata[d], e.rdata);
`ifdef BUS_SRAM_SLAVE_ERR_EN
                        chk($sformatf("dut%0d_ack_errn", d), 32'(errn[d]), 32'(e.errn));
`endif
                    end
                end else begin
                    chk($sformatf("dut%0d_idle_rdata", d), rdata[d], 32'd0);
`ifdef BUS_SRAM_SLAVE_ERR_EN
                    chk($sformatf("dut%0d_idle_errn", d), 32'(errn[d]), 32'd1);
`endif
                end
            end
        end
    end

    initial begin : stim
        exp_t e;
        reset_n = 1'b0;
        asn     = '1;
        rw      = '1;
        for (int d = 0; d < 3; d++) begin
            addr[d]  = '0;
            wdata[d] = '0;
        end

        // dut, rw, addr, wdata, expected rdata, expected errn, extra hold cycles
        add(0, 1'b0, 30'h005, 32'hDEADBEEF, 32'h0, 1'b1, 0);
        add(0, 1'b1, 30'h005, 32'h0,        32'hDEADBEEF, 1'b1, 0);
        add(0, 1'b0, 30'h001, 32'h11111111, 32'h0, 1'b1, 0);
        add(0, 1'b0, 30'h002, 32'h22222222, 32'h0, 1'b1, 0);
        add(0, 1'b0, 30'h003, 32'h33333333, 32'h0, 1'b1, 0);
        add(0, 1'b1, 30'h001, 32'h0,        32'h11111111, 1'b1, 0);
        add(0, 1'b1, 30'h002, 32'h0,        32'h22222222, 1'b1, 0);
        add(0, 1'b1, 30'h003, 32'h0,        32'h33333333, 1'b1, 0);
        add(0, 1'b0, 30'h000, 32'hCAFEF00D, 32'h0, 1'b1, 0);
        add(0, 1'b0, 30'h100, 32'h0BADF00D, 32'h0, ERR_EN ? 1'b0 : 1'b1, 0);
        add(0, 1'b1, 30'h000, 32'h0, ERR_EN ? 32'hCAFEF00D : 32'h0BADF00D, 1'b1, 0);
        add(0, 1'b1, 30'h100, 32'h0, ERR_EN ? 32'h0 : 32'h0BADF00D, ERR_EN ? 1'b0 : 1'b1, 0);
        add(0, 1'b1, 30'h305, 32'h0, ERR_EN ? 32'h0 : 32'hDEADBEEF, ERR_EN ? 1'b0 : 1'b1, 0);
        add(1, 1'b0, 30'h007, 32'h00000077, 32'h0, 1'b1, 0);
        add(1, 1'b1, 30'h007, 32'h0,        32'h00000077, 1'b1, 5);
        add(1, 1'b0, 30'h008, 32'h88888888, 32'h0, 1'b1, 0);
        add(1, 1'b1, 30'h008, 32'h0,        32'h88888888, 1'b1, 0);
        add(1, 1'b1, 30'h007, 32'h0,        32'h00000077, 1'b1, 0);
        add(2, 1'b0, 30'h010, 32'h55AA55AA, 32'h0, 1'b1, 0);
        add(2, 1'b1, 30'h010, 32'h0,        32'h55AA55AA, 1'b1, 0);

        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("dut%0d_reset_rdyn", d), 32'(rdyn[d]), 32'd1);
            chk($sformatf("dut%0d_reset_rdata", d), rdata[d], 32'd0);
        end
        reset_n = 1'b1;

        foreach (vecs[i]) do_txn(vecs[i]);

        // Abort during WAIT (3 wait states): no ack, no write.
        drive(2, 1'b0, 1'b0, 30'h010, 32'h12345678);
        @(posedge clk);
        @(negedge clk);
        chk("abort_wait_rdyn", 32'(rdyn[2]), 32'd1);
        @(negedge clk);
        asn[2] = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_ack", 32'(rdyn[2]), 32'd1);
        end
        do_txn('{d: 2, rw: 1'b1, addr: 30'h010, wdata: 32'h0,
                 rdata: 32'h55AA55AA, errn: 1'b1, hold: 0});

        // Reset while in ACK of a write: the write is dropped.
        drive(0, 1'b0, 1'b0, 30'h005, 32'hA5A5A5A5);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_ack_rdyn", 32'(rdyn[0]), 32'd1);
        chk("rst_ack_rdata", rdata[0], 32'd0);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        asn[0] = 1'b1;
        repeat (2) @(negedge clk);
        do_txn('{d: 0, rw: 1'b1, addr: 30'h005, wdata: 32'h0,
                 rdata: 32'hDEADBEEF, errn: 1'b1, hold: 0});

        // Reset during the ready pulse of a read clears outputs at once.
        e.cyc = cyc + 3; e.rdata = 32'hDEADBEEF; e.errn = 1'b1;
        sb_push(0, e);
        drive(0, 1'b0, 1'b1, 30'h005, 32'h0);
        @(posedge clk);
        repeat (3) @(negedge clk);
        #1;
        chk("pulse_rdyn_before_rst", 32'(rdyn[0]), 32'd0);
        chk("pulse_rdata_before_rst", rdata[0], 32'hDEADBEEF);
        reset_n = 1'b0;
        #1;
        chk("pulse_rst_rdyn", 32'(rdyn[0]), 32'd1);
        chk("pulse_rst_rdata", rdata[0], 32'd0);
`ifdef BUS_SRAM_SLAVE_ERR_EN
        chk("pulse_rst_errn", 32'(errn[0]), 32'd1);
`endif
        asn[0] = 1'b1;
        #1;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        do_txn('{d: 0, rw: 1'b1, addr: 30'h003, wdata: 32'h0,
                 rdata: 32'h33333333, errn: 1'b1, hold: 0});

        repeat (8) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("dut%0d_missing_acks", d), 32'(sb_size(d)), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_sram_slave.md
BUS_SRAM_SLAVE -- requirements
Module: bus_sram_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: number of word-address bits decoded; memory depth is 2**ADDR_WIDTH 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 1, range 0..15: wait states inserted before ready.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 s_addr  input  30  word address from the bus master mux.
REQ-006 s_asn  input  1  address strobe, active-low.
REQ-007 s_rw  input  1  1 = read, 0 = write.
REQ-008 s_wdata  input  32  write data.
REQ-009 s_rdata  output  32  read data, valid only while s_rdyn = 0 on a read.
REQ-010 s_rdyn  output  1  ready, active-low, one-cycle pulse per transaction.

Function
REQ-011 FSM states: IDLE, WAIT, ACK, HOLD; registered state.
REQ-012 IDLE: s_asn = 0 at a clock edge captures s_addr[ADDR_WIDTH-1:0], s_rw and s_wdata, clears the wait counter, and moves to WAIT (WAIT_CYCLES > 0) or ACK (WAIT_CYCLES = 0).
REQ-013 WAIT: counter increments once per cycle; transition to ACK on the edge where the counter reaches WAIT_CYCLES-1.
REQ-014 Latency: s_asn sampled low at edge N, s_rdyn = 0 during the cycle following edge N+1+WAIT_CYCLES.
REQ-015 ACK: s_rdyn = 0 for exactly one cycle; read drives s_rdata = mem[captured addr]; write commits captured s_wdata to mem[captured addr] at the edge leaving ACK.
REQ-016 Outside ACK, s_rdyn = 1 and s_rdata = 0; s_rdata = 0 during a write ACK.
REQ-017 ACK moves to HOLD unconditionally; HOLD stays until s_asn = 1 is sampled, then moves to IDLE; no new transaction is accepted in HOLD, so one strobe gives exactly one ack.
REQ-018 Abort: s_asn = 1 sampled in WAIT returns to IDLE with no ack and no memory write.
REQ-019 s_addr, s_rw and s_wdata changes after capture have no effect on the transaction in flight.
REQ-020 Back-to-back: s_asn high for one cycle after ack, then low again, starts a new transaction from IDLE; the minimum period is 3+WAIT_CYCLES cycles.
REQ-021 Read-after-write to the same address returns the newly written data.

Reset
REQ-022 reset_n = 0 immediately forces state IDLE, counter 0, s_rdyn = 1 and s_rdata = 0, independent of clk.
REQ-023 Reset during WAIT or ACK discards the pending write; memory contents are not reset and are undefined until written.
REQ-024 The first transaction is accepted at the first rising edge after reset_n returns to 1 with s_asn = 0.

Configuration
REQ-025 Macro BUS_SRAM_SLAVE_ERR_EN defined: adds output s_errn (1 bit, active-low, reset 1). s_errn = 0 together with s_rdyn = 0 when captured s_addr[29:ADDR_WIDTH] is nonzero. An erroring write does not modify memory, and an erroring read returns s_rdata = 0.
REQ-026 Macro BUS_SRAM_SLAVE_ERR_EN undefined: no s_errn port; s_addr[29:ADDR_WIDTH] is ignored and addresses alias into the memory.

Verification
REQ-027 WAIT_CYCLES=1: write 0xDEADBEEF to addr 0x05 -> s_rdyn low in the 3rd cycle after the strobe edge; read addr 0x05 -> s_rdata = 0xDEADBEEF while s_rdyn = 0.
REQ-028 WAIT_CYCLES=0: read strobe at edge N -> s_rdyn = 0 during the cycle after edge N+1; s_asn held low 5 more cycles -> exactly one ack pulse.
REQ-029 Abort: s_asn raised during WAIT of a write of 0x12345678 to addr 0x10 (WAIT_CYCLES=3) -> no ack; a later read of 0x10 returns the prior value.
REQ-030 Reset_n pulsed low during ACK of a write of 0xA5A5A5A5 -> s_rdyn = 1 immediately and memory is unchanged; a read after reset returns the old data.
REQ-031 BUS_SRAM_SLAVE_ERR_EN with ADDR_WIDTH=8: write to addr 0x100 -> s_errn = 0 and s_rdyn = 0 together, addr 0x00 unchanged; without the macro, the same write overwrites addr 0x00.
REQ-032 Back-to-back reads of addr 0x01, 0x02, 0x03 with a one-cycle s_asn high gap -> three acks with the correct data, spaced 3+WAIT_CYCLES cycles apart.
